// File: rtl/quadrature_gen.sv
// Quadrature A/B generator: steps a Gray-coded position one transition at a time
// toward a commanded target, one step per programmable interval.
module quadrature_gen #(
    parameter int DATA_LEN  = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_LEN-1:0]  target,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] period,
    output logic                 a,
    output logic                 b,
    output logic [DATA_LEN-1:0]  position,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [DATA_LEN-1:0]   r_tgt;
    logic [DIV_WIDTH-1:0]  r_timer;
    logic [DATA_LEN-1:0]   r_pos;
    logic                  r_a;
    logic                  r_b;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state;
    logic [DATA_LEN-1:0]   w_tgt;
    logic [DIV_WIDTH-1:0]  w_timer;
    logic [DATA_LEN-1:0]   w_pos;
    logic [DATA_LEN-1:0]   w_step_pos;
    logic [DATA_LEN-1:0]   w_tgt_eff;
    logic                  w_busy;
    logic                  w_done;
    logic [1:0]            w_ab;

    // Gray phase of a position: {a, b} = {p[1]^p[0], p[1]}
    function automatic logic [1:0] phase_of(input logic [DATA_LEN-1:0] p);
        return {p[1] ^ p[0], p[1]};
    endfunction

    // Next-state and next-output logic for the IDLE/RUN controller
    always_comb begin
        w_state    = r_state;
        w_tgt      = r_tgt;
        w_timer    = r_timer;
        w_pos      = r_pos;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_step_pos = r_pos;
        w_tgt_eff  = r_tgt;

        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_tgt = target;
                    if (target != r_pos) begin
                        w_timer = period;
                        w_busy  = 1'b1;
                        w_state = S_RUN;
                    end else begin
                        w_done = 1'b1;
                    end
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_RUN: begin
                // A step always uses the tgt held before any same-edge load
                if (r_timer == {DIV_WIDTH{1'b0}}) begin
                    if (r_tgt > r_pos) begin
                        w_step_pos = r_pos + DATA_LEN'(1);
                    end else if (r_tgt < r_pos) begin
                        w_step_pos = r_pos - DATA_LEN'(1);
                    end else begin
                        w_step_pos = r_pos;
                    end
                    w_timer = period;
                end else begin
                    w_timer = r_timer - DIV_WIDTH'(1);
                end
                w_tgt_eff = load ? target : r_tgt;
                w_tgt     = w_tgt_eff;
                w_pos     = w_step_pos;
                if (w_step_pos == w_tgt_eff) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_state = S_RUN;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase

        w_ab = phase_of(w_pos);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tgt   <= {DATA_LEN{1'b0}};
            r_timer <= {DIV_WIDTH{1'b0}};
            r_pos   <= {DATA_LEN{1'b0}};
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_tgt   <= w_tgt;
            r_timer <= w_timer;
            r_pos   <= w_pos;
            r_a     <= w_ab[1];
            r_b     <= w_ab[0];
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign a        = r_a;
    assign b        = r_b;
    assign position = r_pos;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
